// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply/divide with HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r;
  logic [WIDTH-1:0] a_q, b_q, rem, diff, rem_fix, mag_a, mag_b;
  logic [2*WIDTH-1:0] p, p_neg;
  logic [WIDTH:0] mul_sum, trial;
  logic sa, sb, q_bit;
  // operand magnitudes, one shift-add step, one restoring-division step, sign fixups
  always_comb begin
    sa = ~op[0] & src_a[WIDTH-1];
    sb = ~op[0] & src_b[WIDTH-1];
    mag_a = sa ? -src_a : src_a;
    mag_b = sb ? -src_b : src_b;
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_q} : '0);
    trial = {rem, p[WIDTH-1]};
    q_bit = trial >= {1'b0, b_q};
    diff = trial[WIDTH-1:0] - b_q;
    p_neg = -p;
    rem_fix = neg_r ? -rem : rem;
  end
  assign busy = state != IDLE;
  // control FSM, datapath iteration and architectural HI/LO update
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      p <= '0;
      rem <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (flush) state <= IDLE;
      else case (state)
        IDLE: if (start) begin
          state <= CALC;
          cnt <= '0;
          is_div <= op[1];
          neg_q <= sa ^ sb;
          neg_r <= sa;
          a_q <= mag_a;
          b_q <= mag_b;
          p <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
          rem <= '0;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
          if (is_div) begin
            rem <= q_bit ? diff : trial[WIDTH-1:0];
            p <= {p[2*WIDTH-1:WIDTH], p[WIDTH-2:0], q_bit};
          end else p <= {mul_sum, p[WIDTH-1:1]};
        end
        FIX: begin
          state <= IDLE;
          done <= 1'b1;
          if (!is_div) {hi, lo} <= neg_q ? p_neg : p;
          else if (b_q != '0) begin
            lo <= neg_q ? p_neg[WIDTH-1:0] : p[WIDTH-1:0];
            hi <= rem_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit at WIDTH=32
module tb_mul_div_unit;
  logic clk, rst, start, flush, hi_we, lo_we, busy, done;
  logic [1:0] op;
  logic [31:0] src_a, src_b, wdata, hi, lo;
  int checks = 0;
  int failures = 0;
  int n;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    chk("busy_at_t", 64'(busy), 64'd0);
    tick(1);
    start = 1'b0;
    chk("busy_t1", 64'(busy), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    launch(o, a, b);
    tick(32);
    chk({tag, "_busy_t33"}, 64'(busy), 64'd1);
    chk({tag, "_nodone_t33"}, 64'(done), 64'd0);
    tick(1);
    chk({tag, "_done_t34"}, 64'(done), 64'd1);
    chk({tag, "_idle_t34"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
    tick(2);
    rst = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    // back-to-back: each op launches in the previous op's done cycle
    run_op("mult", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 2'b01, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    tick(1);
    chk("done_one_cycle", 64'(done), 64'd0);
    hi_we = 1'b1; wdata = 32'h1234;
    tick(1);
    chk("mthi", 64'(hi), 64'h1234);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    tick(1);
    lo_we = 1'b0;
    chk("mtlo", 64'(lo), 64'h5678);
    chk("mtlo_keeps_hi", 64'(hi), 64'h1234);
    run_op("div0", 2'b10, 32'd9, 32'd0, 32'h1234, 32'h5678);
    tick(1);
    launch(2'b01, 32'd5, 32'd7);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_nodone", 64'(done), 64'd0);
    chk("flush_hi", 64'(hi), 64'h1234);
    chk("flush_lo", 64'(lo), 64'h5678);
    run_op("after_flush", 2'b01, 32'd5, 32'd7, 32'd0, 32'd35);
    tick(1);
    flush = 1'b1; start = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd2;
    tick(1);
    flush = 1'b0; start = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (done) n++;
    end
    chk("flush_start_nodone", 64'(n), 64'd0);
    chk("flush_start_lo", 64'(lo), 64'd35);
    launch(2'b01, 32'd3, 32'd3);
    tick(3);
    hi_we = 1'b1; wdata = 32'hAA;
    tick(1);
    hi_we = 1'b0;
    chk("mthi_in_calc", 64'(hi), 64'd0);
    tick(29);
    chk("calc_wr_done", 64'(done), 64'd1);
    chk("calc_wr_hi", 64'(hi), 64'd0);
    chk("calc_wr_lo", 64'(lo), 64'd9);
    tick(1);
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (done) n++;
    end
    chk("midrst_nodone", 64'(n), 64'd0);
    chk("midrst_lo_after", 64'(lo), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
